// File: rtl/gpu_pkg.sv
// Shared types and constants for the rasterizer command scheduler.
// Holds the scheduler state encoding, command opcodes, framebuffer geometry and vertex layout.
package gpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ARM   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_CLEAR = 3'd4
   } state_t;

   localparam logic OP_TRI   = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   // Vertex is packed as {x, y}, 10 bits each.
   localparam int VTX_W = 20;
   localparam int VX_HI = 19;
   localparam int VX_LO = 10;
   localparam int VY_HI = 9;
   localparam int VY_LO = 0;

   function automatic logic [VTX_W-1:0] vtx_pack(input logic [9:0] x, input logic [9:0] y);
      return {x, y};
   endfunction

   function automatic logic [9:0] vtx_x(input logic [VTX_W-1:0] v);
      return v[VX_HI:VX_LO];
   endfunction

   function automatic logic [9:0] vtx_y(input logic [VTX_W-1:0] v);
      return v[VY_HI:VY_LO];
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count and full/empty flags.
// Push while full and pop while empty are ignored; DEPTH must be a power of two.
module cmd_fifo #(
   parameter int W     = 69,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/raster_sched.sv
// Command scheduler for the triangle rasterizer: queues TRI/CLEAR commands, sequences the
// rasterizer handshake, runs the clear engine and owns the framebuffer write port.
module raster_sched
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_WIDTH   = gpu_pkg::FB_WIDTH,
   parameter int FB_HEIGHT  = gpu_pkg::FB_HEIGHT,
   parameter int ADDR_W     = 19,
   parameter int COLOR_W    = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_op,
   input  logic [VTX_W-1:0]   cmd_v0,
   input  logic [VTX_W-1:0]   cmd_v1,
   input  logic [VTX_W-1:0]   cmd_v2,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic               rast_start,
   output logic [VTX_W-1:0]   rast_v0,
   output logic [VTX_W-1:0]   rast_v1,
   output logic [VTX_W-1:0]   rast_v2,
   output logic [COLOR_W-1:0] rast_color,
   input  logic               rast_done,
   input  logic [ADDR_W-1:0]  rast_addr,
   input  logic [COLOR_W-1:0] rast_dout,
   input  logic               rast_wen,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_dout,
   output logic               fb_wen,
   output logic               busy,
   output logic [15:0]        tri_count,
   output state_t             dbg_state
);

   localparam int ENTRY_W = 1 + 3 * VTX_W + COLOR_W;
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

   state_t               state_q, state_d;
   logic [VTX_W-1:0]     v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
   logic [15:0]          tri_count_q, tri_count_d;

   logic [ENTRY_W-1:0]   fifo_din, fifo_dout;
   logic                 fifo_full, fifo_empty, fifo_pop;
   logic                 e_op;
   logic [VTX_W-1:0]     e_v0, e_v1, e_v2;
   logic [COLOR_W-1:0]   e_color;

   assign fifo_din = {cmd_op, cmd_v0, cmd_v1, cmd_v2, cmd_color};
   assign {e_op, e_v0, e_v1, e_v2, e_color} = fifo_dout;
   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

   cmd_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cmd_valid),
      .din     (fifo_din),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      v0_d        = v0_q;
      v1_d        = v1_q;
      v2_d        = v2_q;
      color_d     = color_q;
      clr_cnt_d   = clr_cnt_q;
      tri_count_d = tri_count_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               color_d = e_color;
               // Vertices only change on a new triangle so the rasterizer inputs stay stable.
               if (e_op == OP_TRI) begin
                  v0_d = e_v0;
                  v1_d = e_v1;
                  v2_d = e_v2;
               end
               clr_cnt_d = '0;
               state_d   = (e_op == OP_CLEAR) ? ST_CLEAR : ST_START;
            end
         end
         ST_START: state_d = ST_ARM;
         // A stale done from the previous triangle may still be high here.
         ST_ARM:   state_d = ST_WAIT;
         ST_WAIT: begin
            if (rast_done) begin
               tri_count_d = tri_count_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
            else                       clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         v0_q        <= '0;
         v1_q        <= '0;
         v2_q        <= '0;
         color_q     <= '0;
         clr_cnt_q   <= '0;
         tri_count_q <= '0;
      end else begin
         state_q     <= state_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         color_q     <= color_d;
         clr_cnt_q   <= clr_cnt_d;
         tri_count_q <= tri_count_d;
      end
   end

   // Framebuffer port owner: clear engine, rasterizer pass-through, or silent.
   always_comb begin
      fb_wen  = 1'b0;
      fb_addr = '0;
      fb_dout = '0;
      case (state_q)
         ST_CLEAR: begin
            fb_wen  = 1'b1;
            fb_addr = clr_cnt_q;
            fb_dout = color_q;
         end
         ST_ARM, ST_WAIT: begin
            fb_wen  = rast_wen;
            fb_addr = rast_addr;
            fb_dout = rast_dout;
         end
         default: ;
      endcase
   end

   assign rast_start = (state_q == ST_START);
   assign rast_v0    = v0_q;
   assign rast_v1    = v1_q;
   assign rast_v2    = v2_q;
   assign rast_color = color_q;
   assign cmd_ready  = !fifo_full;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;
   assign tri_count  = tri_count_q;
   assign dbg_state  = state_q;

endmodule
